// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed little-endian data memory with a
// request/response handshake and programmable access latency.
//
// Parameters
//   ADDR_W      address width in bits
//   DEPTH_BYTES memory size in bytes (power of two, >= 4)
//   LATENCY     cycles from acceptance to response of a legal access (>= 1)
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-low reset
//   req_i       request valid, accepted while ready_o=1
//   we_i        1 = store, 0 = load
//   size_i      00 byte, 01 halfword, 10 word, 11 illegal
//   unsigned_i  load extension: 1 = zero-extend, 0 = sign-extend
//   addr_i      byte address
//   data_i      store data (low 8/16/32 bits used)
//   ready_o     block is idle and accepts req_i (combinational from state)
//   valid_o     one-cycle response pulse
//   data_o      load result; 0 for stores and errors; held between responses
//   err_o       error flag, meaningful while valid_o=1; held between responses
//
// Build option
//   DMEM_MISALIGN_EN  when defined, misaligned halfword/word accesses are
//                     legal (bytes handled individually); range and size
//                     checks still apply.
//
// Timing: a legal access completes LATENCY edges after acceptance; an errored
// access skips the countdown and completes one edge after acceptance. Each
// access occupies IDLE, the BUSY countdown and one RESP cycle.

module data_memory_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [31:0]       data_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CHK_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request captured at acceptance; error is decided on the live inputs.
  typedef struct packed {
    logic             we;
    logic [1:0]       size;
    logic             uns;
    logic [IDX_W-1:0] idx;
    logic [31:0]      wdata;
    logic             err;
  } req_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q;

  logic [2:0]       nbytes_c;
  logic             range_err_c;
  logic             align_err_c;
  logic             req_err_c;

  logic             access_c;
  logic             mem_we_c;
  logic [3:0]       be_c;
  logic [IDX_W-1:0] byte_idx_c [4];
  logic [31:0]      rd_word_c;
  logic [31:0]      load_c;

  logic [7:0]       mem [DEPTH_BYTES];

  // Error evaluation of the incoming request.
  always_comb begin
    nbytes_c = 3'd4;
    case (size_i)
      2'b00:   nbytes_c = 3'd1;
      2'b01:   nbytes_c = 3'd2;
      default: nbytes_c = 3'd4;
    endcase
    // Extra bit keeps addr + nbytes from wrapping near the top of the space.
    range_err_c = (CHK_W'(addr_i) + CHK_W'(nbytes_c)) > CHK_W'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_EN
    align_err_c = 1'b0;
`else
    align_err_c = ((size_i == 2'b01) && addr_i[0]) ||
                  ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
`endif
    req_err_c = (size_i == 2'b11) || range_err_c || align_err_c;
  end

  // State and countdown register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_q <= '0;
    end else if ((state_q == ST_IDLE) && req_i) begin
      req_q <= '{we:    we_i,
                 size:  size_i,
                 uns:   unsigned_i,
                 idx:   addr_i[IDX_W-1:0],
                 wdata: data_i,
                 err:   req_err_c};
    end
  end

  // Next-state and countdown logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          state_d = ST_BUSY;
          // Errors bypass the latency so the response lands one edge later.
          cnt_d   = req_err_c ? '0 : CNT_W'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake, byte lane and load-data logic.
  always_comb begin
    ready_o  = (state_q == ST_IDLE);
    access_c = (state_q == ST_BUSY) && (cnt_q == '0);
    mem_we_c = access_c && req_q.we && !req_q.err;

    be_c = 4'b0000;
    case (req_q.size)
      2'b00:   be_c = 4'b0001;
      2'b01:   be_c = 4'b0011;
      2'b10:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase

    // Byte-wise addressing also covers misaligned accesses when enabled.
    for (int k = 0; k < 4; k++) begin
      byte_idx_c[k] = req_q.idx + IDX_W'(k);
    end
    rd_word_c = {mem[byte_idx_c[3]], mem[byte_idx_c[2]],
                 mem[byte_idx_c[1]], mem[byte_idx_c[0]]};

    load_c = rd_word_c;
    case (req_q.size)
      2'b00:   load_c = req_q.uns ? {24'd0, rd_word_c[7:0]}
                                  : {{24{rd_word_c[7]}}, rd_word_c[7:0]};
      2'b01:   load_c = req_q.uns ? {16'd0, rd_word_c[15:0]}
                                  : {{16{rd_word_c[15]}}, rd_word_c[15:0]};
      default: load_c = rd_word_c;
    endcase
  end

  // Registered response; data/err hold until the next access completes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= access_c;
      if (access_c) begin
        err_o  <= req_q.err;
        data_o <= (req_q.err || req_q.we) ? '0 : load_c;
      end
    end
  end

  // Storage; contents survive reset, and reset cancels a pending store.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_c[k]) begin
          mem[byte_idx_c[k]] <= req_q.wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed plus randomized transactions against a
// byte-array reference model of the data memory.

module tb_data_memory_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk_i;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        err_o;

  int n_cmp;
  int n_err;

  logic [7:0] ref_mem [DEPTH];
  bit         known   [DEPTH];

  data_memory_ctrl #(
    .ADDR_W      (32),
    .DEPTH_BYTES (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .err_o      (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction: wait ready, issue, wait response, check vs model.
  task automatic do_txn(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got);
    int          n;
    bit          exp_err;
    int          exp_lat;
    int          lat;
    int          waited;
    bit          known_all;
    logic [31:0] exp_d;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_err = (sz == 2'b11) || ((longint'(addr) + longint'(n)) > longint'(DEPTH));
`ifndef DMEM_MISALIGN_EN
    if ((sz == 2'b01 && (addr % 2) != 0) || (sz == 2'b10 && (addr % 4) != 0))
      exp_err = 1'b1;
`endif
    exp_lat   = exp_err ? 1 : int'(LAT);
    known_all = 1'b1;
    exp_d     = 32'd0;
    if (!exp_err && !we) begin
      for (int k = 0; k < n; k++) begin
        if (!known[int'(addr) + k]) known_all = 1'b0;
        exp_d = exp_d | (32'(ref_mem[int'(addr) + k]) << (8 * k));
      end
      if (!uns && n < 4 && exp_d[8*n-1])
        exp_d = exp_d | (32'hFFFF_FFFF << (8 * n));
    end

    waited = 0;
    while (!ready_o && waited < 20) begin
      @(posedge clk_i); #1;
      waited++;
    end
    chk({tag, ":ready"}, 32'(ready_o), 32'd1);

    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns;
    addr_i = addr; data_i = wd;
    @(posedge clk_i); #1;
    // Scramble the bus after acceptance: the block must use the latched copy.
    req_i = 1'b0; addr_i = $urandom; data_i = $urandom;
    size_i = 2'($urandom); we_i = 1'($urandom); unsigned_i = 1'($urandom);

    lat = 0;
    while (!valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":err"}, 32'(err_o), 32'(exp_err));
    if (exp_err || we || known_all)
      chk({tag, ":data"}, data_o, exp_d);
    got = data_o;

    if (we && !exp_err) begin
      for (int k = 0; k < n; k++) begin
        ref_mem[int'(addr) + k] = 8'((wd >> (8 * k)) & 32'hFF);
        known[int'(addr) + k]   = 1'b1;
      end
    end

    @(posedge clk_i); #1;
    chk({tag, ":pulse"}, 32'(valid_o), 32'd0);
    chk({tag, ":ready_after"}, 32'(ready_o), 32'd1);
    chk({tag, ":hold"}, data_o, got);
  endtask

  logic [31:0] g;
  int          acc_cyc [$];
  int          vcnt;

  initial begin
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = 8'h00;
      known[i]   = 1'b0;
    end
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00;
    unsigned_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data",  data_o, 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Word store and readback, sub-word loads.
    do_txn("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, g);
    do_txn("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g);
    chk("ld_w10_val", g, 32'hDEADBEEF);
    do_txn("ld_b10u", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, g);
    chk("ld_b10u_val", g, 32'h000000EF);
    do_txn("ld_b13s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, g);
    chk("ld_b13s_val", g, 32'hFFFFFFDE);
    do_txn("ld_b13u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, g);
    chk("ld_b13u_val", g, 32'h000000DE);
    do_txn("ld_h12s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, g);
    chk("ld_h12s_val", g, 32'hFFFFDEAD);

    // Misaligned word load.
    do_txn("st_b14", 1'b1, 2'b00, 1'b0, 32'h14, 32'h00000077, g);
    do_txn("ld_w11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, g);
`ifdef DMEM_MISALIGN_EN
    chk("ld_w11_val", g, 32'h77DEADBE);
`else
    chk("ld_w11_val", g, 32'h00000000);
`endif

    // Halfword store merges into the word.
    do_txn("st_h12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE1234, g);
    do_txn("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g);
    chk("ld_w10b_val", g, 32'h1234BEEF);

    // Range edges.
    do_txn("st_w3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h01020304, g);
    do_txn("ld_w3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, g);
    chk("ld_w3fc_val", g, 32'h01020304);
    do_txn("ld_w400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, g);
    chk("ld_w400_err", 32'(err_o), 32'd1);
    do_txn("ld_w3fe", 1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0, g);
    chk("ld_w3fe_err", 32'(err_o), 32'd1);

    // Illegal size store leaves memory untouched.
    do_txn("st_sz3", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, g);
    chk("st_sz3_err", 32'(err_o), 32'd1);
    do_txn("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g);
    chk("ld_w10c_val", g, 32'h1234BEEF);

    // Reset during BUSY drops an in-flight store.
    do_txn("st_b20", 1'b1, 2'b00, 1'b0, 32'h20, 32'h000000A5, g);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; addr_i = 32'h20; data_i = 32'h55;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    chk("rstb_busy", 32'(ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rstb_ready", 32'(ready_o), 32'd1);
    chk("rstb_data", data_o, 32'd0);
    vcnt = 0;
    repeat (2) begin
      @(posedge clk_i); #1;
      if (valid_o) vcnt++;
    end
    rst_i = 1'b1;
    repeat (4) begin
      @(posedge clk_i); #1;
      if (valid_o) vcnt++;
    end
    chk("rstb_no_valid", 32'(vcnt), 32'd0);
    do_txn("ld_b20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, g);
    chk("ld_b20_val", g, 32'h000000A5);

    // req_i held for 9 cycles: accepts spaced by IDLE + LAT BUSY + RESP.
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
    addr_i = 32'h10; data_i = 32'h0;
    for (int c = 0; c < 9; c++) begin
      if (ready_o) acc_cyc.push_back(c);
      @(posedge clk_i); #1;
    end
    req_i = 1'b0;
    repeat (LAT + 3) @(posedge clk_i);
    #1;
    chk("b2b_count", 32'(acc_cyc.size()), 32'd3);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(LAT + 2));
    chk("b2b_idle", 32'(ready_o), 32'd1);

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      logic        rwe;
      logic [1:0]  rsz;
      logic        runs;
      logic [31:0] raddr;
      int          r;
      rwe  = 1'($urandom);
      rsz  = 2'($urandom_range(0, 3));
      runs = 1'($urandom);
      r    = $urandom_range(0, 9);
      if (r < 7)      raddr = 32'($urandom_range(0, 63));
      else if (r < 9) raddr = 32'($urandom_range(1008, 1023));
      else            raddr = 32'($urandom_range(1024, 1039));
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'b01) raddr = raddr & ~32'd1;
        if (rsz == 2'b10) raddr = raddr & ~32'd3;
      end
      do_txn("rnd", rwe, rsz, runs, raddr, $urandom, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
